// File: rtl/updown_counter16.sv
// updown_counter16: WIDTH-bit synchronous up/down counter with clear, set-to-all-ones,
// parallel preload, count enable and selectable wrap or saturate at the terminal value.
// The registered overflow flag reports a count step that was blocked in saturate mode.
//
// Build option: define UCNT_STICKY_OVF_EN to make overflow sticky. Once set, it then
// holds through later counting and clears only on _areset, _aset or _load.
// With the macro undefined, overflow clears on the next successful step or wrap.
module updown_counter16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             _areset,
  input  logic             _aset,
  input  logic             _load,
  input  logic [WIDTH-1:0] preld_val,
  input  logic             _updown,
  input  logic             _wrapstop,
  input  logic             _carry_in,
  output logic [WIDTH-1:0] dcount,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] AllOnes  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] AllZeros = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] One      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             at_term;
  logic [WIDTH-1:0] step_val;
  logic             ovf_after_step;

  // Terminal value depends on direction: all-ones going up, all-zeros going down.
  always_comb begin
    at_term  = _updown ? (count_q == AllOnes) : (count_q == AllZeros);
    step_val = _updown ? (count_q + One) : (count_q - One);
  end

  // Flag value after a successful step or wrap; the sticky build keeps a prior block.
  always_comb begin
`ifdef UCNT_STICKY_OVF_EN
    ovf_after_step = ovf_q;
`else
    ovf_after_step = 1'b0;
`endif
  end

  // Next-state selection in priority order: reset, set, load, count.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (_areset) begin
      count_d = AllZeros;
      ovf_d   = 1'b0;
    end else if (_aset) begin
      count_d = AllOnes;
      ovf_d   = 1'b0;
    end else if (_load) begin
      count_d = preld_val;
      ovf_d   = 1'b0;
    end else if (_carry_in) begin
      if (at_term && !_wrapstop) begin
        // Saturate: the count holds and the blocked step is flagged.
        count_d = count_q;
        ovf_d   = 1'b1;
      end else begin
        // Modulo arithmetic covers both the normal step and the wrap.
        count_d = step_val;
        ovf_d   = ovf_after_step;
      end
    end
  end

  // State register with synchronous active-high reset folded into next-state logic.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    ovf_q   <= ovf_d;
  end

  assign dcount   = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_updown_counter16.sv
// Scoreboard bench for updown_counter16: the stimulus process pushes the expected
// post-edge state; a monitor pops and compares just after each rising edge.
module tb_updown_counter16;

`ifdef UCNT_STICKY_OVF_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        _areset = 1'b0;
  logic        _aset = 1'b0;
  logic        _load = 1'b0;
  logic [15:0] preld_val = 16'h0000;
  logic        _updown = 1'b1;
  logic        _wrapstop = 1'b1;
  logic        _carry_in = 1'b0;
  logic [15:0] dcount;
  logic        overflow;

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  updown_counter16 #(.WIDTH(16)) dut (
    .clk       (clk),
    ._areset   (_areset),
    ._aset     (_aset),
    ._load     (_load),
    .preld_val (preld_val),
    ._updown   (_updown),
    ._wrapstop (_wrapstop),
    ._carry_in (_carry_in),
    .dcount    (dcount),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per rising edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (dcount !== e.cnt) begin
          n_fails++;
          $display("FAIL %s dcount: got %h expected %h", e.name, dcount, e.cnt);
        end
        n_checks++;
        if (overflow !== e.ovf) begin
          n_fails++;
          $display("FAIL %s overflow: got %b expected %b", e.name, overflow, e.ovf);
        end
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic cyc(input bit rst, input bit st, input bit ld, input logic [15:0] pv,
                     input bit ud, input bit ws, input bit ci,
                     input logic [15:0] ecnt, input bit eovf, input string nm);
    exp_t e;
    @(negedge clk);
    _areset   = rst;
    _aset     = st;
    _load     = ld;
    preld_val = pv;
    _updown   = ud;
    _wrapstop = ws;
    _carry_in = ci;
    e.cnt  = ecnt;
    e.ovf  = eovf;
    e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    logic [15:0] v;
    int          budget;

    // Reset then count up 1..5.
    cyc(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, "reset");
    for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 16'h0000, 1, 1, 1, 16'(i), 0, "count_up");

    // Load 0x00FC then count up to 0x0101.
    cyc(0, 0, 1, 16'h00FC, 1, 1, 1, 16'h00FC, 0, "load");
    v = 16'h00FC;
    for (int i = 0; i < 5; i++) begin
      v = v + 16'd1;
      cyc(0, 0, 0, 16'h0000, 1, 1, 1, v, 0, "load_up");
    end

    // Down from 0x0101 to 0x00FC.
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 16'h0100, 0, "down");
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 16'h00FF, 0, "down");
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 16'h00FE, 0, "down");
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 16'h00FD, 0, "down");
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 16'h00FC, 0, "down");

    // Wrap up through 0xFFFF.
    cyc(0, 1, 0, 16'h0000, 1, 1, 1, 16'hFFFF, 0, "aset_wrap");
    for (int i = 0; i <= 4; i++) cyc(0, 0, 0, 16'h0000, 1, 1, 1, 16'(i), 0, "wrap_up");

    // Saturate up at 0xFFFF.
    cyc(0, 1, 0, 16'h0000, 1, 0, 1, 16'hFFFF, 0, "aset_stop");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 16'h0000, 1, 0, 1, 16'hFFFF, 1, "stop_up");
    // Reversing direction steps away; overflow clears unless sticky.
    cyc(0, 0, 0, 16'h0000, 0, 0, 1, 16'hFFFE, Sticky, "stop_reverse");
    // Load clears overflow in either build.
    cyc(0, 0, 1, 16'h8000, 0, 0, 1, 16'h8000, 0, "load_clr_ovf");
    cyc(0, 0, 0, 16'h0000, 0, 0, 1, 16'h7FFF, 0, "down_mid");

    // Saturate down at 0x0000, then hold with enable low.
    cyc(0, 0, 1, 16'h0000, 0, 0, 1, 16'h0000, 0, "load_zero");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 1, "stop_down");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, "hold_ovf");
    // Wrap down 0x0000 -> 0xFFFF.
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 16'hFFFF, Sticky, "wrap_down");
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 16'hFFFE, Sticky, "wrap_down2");
    // aset clears overflow in either build.
    cyc(0, 1, 0, 16'h0000, 0, 1, 1, 16'hFFFF, 0, "aset_clr");

    // Priority and enable.
    cyc(0, 0, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, "pre_prio");
    cyc(1, 1, 1, 16'h1234, 1, 1, 1, 16'h0000, 0, "prio_all");
    cyc(0, 1, 1, 16'h1234, 1, 1, 1, 16'hFFFF, 0, "prio_aset_load");
    cyc(0, 0, 1, 16'h1234, 1, 1, 1, 16'h1234, 0, "prio_load");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234, 0, "freeze");
    cyc(0, 0, 0, 16'h0000, 1, 1, 1, 16'h1235, 0, "resume");
    cyc(1, 0, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, "reset_mid");

    // Drain the scoreboard within a bounded number of cycles.
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/updown_counter16.md
Name: updown_counter16

Overview:
- 16-bit synchronous up/down counter with synchronous clear, synchronous set-to-all-ones, parallel preload, count enable, and selectable wrap or saturate at the terminal value.
- Registered overflow flag reports a count attempt blocked in saturate mode.
- General-purpose counter/timer primitive, instantiated directly by control logic in the datapath.

Parameters:
- WIDTH, 16, counter width in bits. All value ports are WIDTH wide. The terminal values are all-ones (up) and all-zeros (down).

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- _areset  input  1  reset, synchronous, active-high. Clears the count and overflow.
- _aset  input  1  synchronous, active-high; forces the count to all-ones.
- _load  input  1  synchronous, active-high; loads preld_val.
- preld_val  input  WIDTH  preload value.
- _updown  input  1  1 = count up, 0 = count down.
- _wrapstop  input  1  1 = wrap at the terminal value, 0 = stop (saturate) at the terminal value.
- _carry_in  input  1  count enable. When 1, the count steps by 1 in the _updown direction; when 0, it holds.
- dcount  output  WIDTH  current count, driven directly from a register.
- overflow  output  1  registered flag: a count was blocked at the terminal value in stop mode.

Behaviour:
- Priority per posedge, highest first: _areset, then _aset, then _load, then count.
- _areset=1: dcount<=0 and overflow<=0. Other inputs are ignored that cycle. Asserting it mid-count takes effect at the next edge.
- _aset=1: dcount<=all-ones (0xFFFF) and overflow<=0.
- _load=1: dcount<=preld_val and overflow<=0.
- Count, when _carry_in=1:
  - Up: dcount<=dcount+1. Down: dcount<=dcount-1. Arithmetic is modulo 2^WIDTH.
  - Terminal value is 0xFFFF when counting up and 0x0000 when counting down.
  - At the terminal value with _wrapstop=1: wraps (0xFFFF->0x0000 up, 0x0000->0xFFFF down); overflow<=0.
  - At the terminal value with _wrapstop=0: dcount holds; overflow<=1 from the next edge onward.
  - Any other value: a normal step; overflow<=0 (non-sticky build).
- _carry_in=0: dcount holds; overflow holds.
- Latency: every control and count effect is visible on dcount/overflow one clock after the sampling edge.
- Changing _updown or _wrapstop takes effect on the next edge; no pipeline.
- Before the first reset, outputs are undefined. The bench must reset first.

Optional Feature:
- Macro UCNT_STICKY_OVF_EN.
- Defined: overflow, once set, stays 1 through later counting (including wraps and direction changes). It clears only on _areset, _aset or _load.
- Not defined: overflow follows the non-sticky rules above; it clears on the next successful step or wrap.

Test Plan:
- Reset and count up: _areset=1 for one cycle, then _carry_in=1, _updown=1. dcount reads 0,1,2,3,4,5 on successive edges; overflow=0.
- Load: preld_val=0x00FC, _load=1 for one cycle. Next edge dcount=0x00FC, then 0x00FD..0x0101 over five edges.
- Down count: _updown=0 for five edges from 0x0101. dcount reads 0x0100,0x00FF,0x00FE,0x00FD,0x00FC.
- Wrap: _wrapstop=1, _aset pulse gives dcount=0xFFFF. Counting up yields 0x0000,0x0001..0x0004; overflow stays 0.
- Stop: _wrapstop=0, _aset pulse gives 0xFFFF. Next edge dcount=0xFFFF with overflow=1, held for 5 cycles. Down-count stop from 0x0000 similarly holds 0x0000 with overflow=1.
- Priority and enable:
  - _areset, _aset and _load all 1 together gives dcount=0.
  - _aset and _load together gives 0xFFFF.
  - _carry_in=0 freezes dcount for 3 cycles.
